// File: rtl/vx_tensor_operand_collector_pkg.sv
// vx_tensor_operand_collector_pkg
// Shared tensor-core constants and types for the operand collector:
//   - default beat / lane geometry of one HMMA step
//   - beat-identity struct (warp id, step, sideband tag) sized for the widest user
//   - collection FSM state enum
//   - saturating 16-bit increment used by the stall counter
package vx_tensor_operand_collector_pkg;

   // Tensor-core geometry
   localparam int TC_NUM_OCTETS = 2;
   localparam int TC_BEATS      = 2;
   localparam int TC_LANES      = 8;

   // Upper bounds for identity fields; instances use the low NW_BITS / TAGW bits.
   localparam int TC_WID_MAXW   = 8;
   localparam int TC_TAG_MAXW   = 32;

   typedef struct packed {
      logic [TC_WID_MAXW-1:0] wid;
      logic [1:0]             step;
      logic [TC_TAG_MAXW-1:0] tag;
   } beat_id_t;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_COLLECT = 1'b1
   } state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/vx_tensor_operand_collector_tile_reg.sv
// vx_tensor_tile_reg
// Output register of the operand collector: holds one assembled tile plus its
// identity behind a valid/ready handshake.
//   clk, reset      : clock, asynchronous active-high reset
//   load            : capture ld_data/ld_id this cycle
//   ld_data, ld_id  : tile payload and identity to capture
//   out_ready       : consumer accepts the held tile
//   out_valid       : a tile is held
//   out_data, out_id: held payload and identity
// A load in the same cycle as a drain wins, so back-to-back tiles see no bubble.
module vx_tensor_tile_reg #(
   parameter int DW  = 1,
   parameter int IDW = 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic [DW-1:0]  ld_data,
   input  logic [IDW-1:0] ld_id,
   input  logic           out_ready,
   output logic           out_valid,
   output logic [DW-1:0]  out_data,
   output logic [IDW-1:0] out_id
);

   logic           valid_q, valid_d;
   logic [DW-1:0]  data_q,  data_d;
   logic [IDW-1:0] id_q,    id_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      id_d    = id_q;
      if (valid_q && out_ready) valid_d = 1'b0;
      if (load) begin
         valid_d = 1'b1;
         data_d  = ld_data;
         id_d    = ld_id;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         id_q    <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         id_q    <= id_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_id    = id_q;

endmodule

// File: rtl/vx_tensor_operand_collector.sv
// vx_tensor_operand_collector
// Per-octet operand collector: gathers BEATS beats of one HMMA step from a
// single warp into an A/B/C tile and presents it on a registered valid/ready port.
//   clk, reset                 : clock, asynchronous active-high reset
//   flush                      : abandon the partial collection
//   in_valid/in_ready          : beat handshake
//   in_wid/in_step/in_tag      : beat identity
//   in_a/in_b/in_c             : one beat of operands (LANES*DATAW each)
//   out_valid/out_ready        : tile handshake
//   out_wid/out_step/out_tag   : tile identity
//   out_a/out_b/out_c          : tile, beat i at [i*LANES*DATAW +: LANES*DATAW]
//   busy                       : collection in progress
//   foreign_stalls             : saturating count of refused foreign-warp cycles
module vx_tensor_operand_collector
   import vx_tensor_operand_collector_pkg::*;
#(
   parameter int LANES   = TC_LANES,
   parameter int DATAW   = 32,
   parameter int BEATS   = TC_BEATS,
   parameter int NW_BITS = 2,
   parameter int TAGW    = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NW_BITS-1:0]           in_wid,
   input  logic [1:0]                   in_step,
   input  logic [TAGW-1:0]              in_tag,
   input  logic [LANES*DATAW-1:0]       in_a,
   input  logic [LANES*DATAW-1:0]       in_b,
   input  logic [LANES*DATAW-1:0]       in_c,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NW_BITS-1:0]           out_wid,
   output logic [1:0]                   out_step,
   output logic [TAGW-1:0]              out_tag,
   output logic [BEATS*LANES*DATAW-1:0] out_a,
   output logic [BEATS*LANES*DATAW-1:0] out_b,
   output logic [BEATS*LANES*DATAW-1:0] out_c,
   output logic                         busy,
   output logic [15:0]                  foreign_stalls
);

   localparam int BW   = LANES * DATAW;
   localparam int TW   = BEATS * BW;
   localparam int BUFN = (BEATS > 1) ? BEATS - 1 : 1;
   localparam int CNTW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int IDW  = NW_BITS + 2 + TAGW;
   localparam logic [CNTW-1:0] LAST_CNT = CNTW'(BEATS - 1);

   state_e               state_q, state_d;
   logic [CNTW-1:0]      cnt_q, cnt_d;
   beat_id_t             lk_q, lk_d;
   logic [15:0]          stall_q, stall_d;
   logic [BUFN*BW-1:0]   buf_a_q, buf_a_d, buf_b_q, buf_b_d, buf_c_q, buf_c_d;

   logic                 matching, id_ok, is_last, out_free, accept, load, buf_we;
   logic [TW-1:0]        tile_a, tile_b, tile_c;
   logic [IDW-1:0]       ld_id, out_id;

   // Lock compare is only meaningful in COLLECT; in IDLE every warp may start a tile.
   assign matching = (state_q == ST_COLLECT) &&
                     (in_wid == lk_q.wid[NW_BITS-1:0]) && (in_step == lk_q.step);
   assign id_ok    = (state_q == ST_IDLE) || matching;
   assign is_last  = (state_q == ST_IDLE) ? (BEATS == 1) : (cnt_q == LAST_CNT);
   assign out_free = !out_valid || out_ready;
   assign in_ready = !flush && id_ok && (!is_last || out_free);
   assign accept   = in_valid && in_ready;
   assign load     = accept && is_last;
   assign buf_we   = accept && !is_last;

   // With BEATS=1 there is no lock yet when the single beat arrives.
   assign ld_id = (state_q == ST_IDLE) ? {in_wid, in_step, in_tag}
                : {lk_q.wid[NW_BITS-1:0], lk_q.step, lk_q.tag[TAGW-1:0]};

   generate
      if (BEATS > 1) begin : g_multi
         assign tile_a = {in_a, buf_a_q};
         assign tile_b = {in_b, buf_b_q};
         assign tile_c = {in_c, buf_c_q};
      end else begin : g_single
         assign tile_a = in_a;
         assign tile_b = in_b;
         assign tile_c = in_c;
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lk_d    = lk_q;
      stall_d = stall_q;
      if (in_valid && (state_q == ST_COLLECT) && !matching) stall_d = sat_inc16(stall_q);
      if (flush) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (accept) begin
         if (state_q == ST_IDLE) begin
            lk_d.wid  = TC_WID_MAXW'(in_wid);
            lk_d.step = in_step;
            lk_d.tag  = TC_TAG_MAXW'(in_tag);
         end
         if (is_last) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end else begin
            state_d = ST_COLLECT;
            cnt_d   = cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      buf_a_d = buf_a_q;
      buf_b_d = buf_b_q;
      buf_c_d = buf_c_q;
      if ((BEATS > 1) && buf_we) begin
         buf_a_d[int'(cnt_q)*BW +: BW] = in_a;
         buf_b_d[int'(cnt_q)*BW +: BW] = in_b;
         buf_c_d[int'(cnt_q)*BW +: BW] = in_c;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         lk_q    <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lk_q    <= lk_d;
         stall_q <= stall_d;
      end
   end

   // Partial-tile storage is always qualified by the FSM, so it needs no reset.
   always_ff @(posedge clk) begin
      buf_a_q <= buf_a_d;
      buf_b_q <= buf_b_d;
      buf_c_q <= buf_c_d;
   end

   vx_tensor_tile_reg #(
      .DW  (3 * TW),
      .IDW (IDW)
   ) u_tile_reg (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .ld_data   ({tile_a, tile_b, tile_c}),
      .ld_id     (ld_id),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  ({out_a, out_b, out_c}),
      .out_id    (out_id)
   );

   assign {out_wid, out_step, out_tag} = out_id;
   assign busy           = (state_q == ST_COLLECT);
   assign foreign_stalls = stall_q;

endmodule

// File: tb/tb_vx_tensor_operand_collector.sv
module tb_vx_tensor_operand_collector;

   typedef struct {
      logic [1:0]   wid;
      logic [1:0]   step;
      logic [7:0]   tag;
      logic [511:0] a, b, c;
   } exp_t;

   int checks = 0;
   int failures = 0;
   exp_t sb[$];
   exp_t mon_e;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Default build: BEATS=2, LANES=8, DATAW=32
   logic         flush, in_valid, in_ready, out_valid, out_ready, busy;
   logic [1:0]   in_wid, in_step, out_wid, out_step;
   logic [7:0]   in_tag, out_tag;
   logic [255:0] in_a, in_b, in_c;
   logic [511:0] out_a, out_b, out_c;
   logic [15:0]  foreign_stalls;

   // Wide build: BEATS=4, LANES=4, DATAW=16
   logic         flush4, in_valid4, in_ready4, out_valid4, out_ready4, busy4;
   logic [1:0]   in_wid4, in_step4, out_wid4, out_step4;
   logic [7:0]   in_tag4, out_tag4;
   logic [63:0]  in_a4, in_b4, in_c4;
   logic [255:0] out_a4, out_b4, out_c4;
   logic [15:0]  foreign_stalls4;

   vx_tensor_operand_collector dut (
      .clk(clk), .reset(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_wid(in_wid), .in_step(in_step), .in_tag(in_tag),
      .in_a(in_a), .in_b(in_b), .in_c(in_c),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_wid(out_wid), .out_step(out_step), .out_tag(out_tag),
      .out_a(out_a), .out_b(out_b), .out_c(out_c),
      .busy(busy), .foreign_stalls(foreign_stalls)
   );

   vx_tensor_operand_collector #(.LANES(4), .DATAW(16), .BEATS(4), .NW_BITS(2), .TAGW(8)) dut4 (
      .clk(clk), .reset(rst), .flush(flush4),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .in_wid(in_wid4), .in_step(in_step4), .in_tag(in_tag4),
      .in_a(in_a4), .in_b(in_b4), .in_c(in_c4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .out_wid(out_wid4), .out_step(out_step4), .out_tag(out_tag4),
      .out_a(out_a4), .out_b(out_b4), .out_c(out_c4),
      .busy(busy4), .foreign_stalls(foreign_stalls4)
   );

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [255:0] fill8(input logic [7:0] v);
      return {32{v}};
   endfunction

   task automatic drive(input int which, input logic v, input logic [1:0] wid, input logic [1:0] step,
                        input logic [7:0] tag, input logic [255:0] a, input logic [255:0] b,
                        input logic [255:0] c);
      if (which == 0) begin
         in_valid = v; in_wid = wid; in_step = step; in_tag = tag;
         in_a = a; in_b = b; in_c = c;
      end else begin
         in_valid4 = v; in_wid4 = wid; in_step4 = step; in_tag4 = tag;
         in_a4 = a[63:0]; in_b4 = b[63:0]; in_c4 = c[63:0];
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input int which, input logic [1:0] wid, input logic [1:0] step,
                       input logic [7:0] tag, input logic [255:0] a, input logic [255:0] b,
                       input logic [255:0] c, output int cyc);
      logic ok;
      ok = 1'b0;
      cyc = 0;
      drive(which, 1'b1, wid, step, tag, a, b, c);
      while (!ok && cyc < 32) begin
         #1;
         ok = (which == 0) ? in_ready : in_ready4;
         cyc++;
         @(posedge clk); #1;
      end
      if (which == 0) in_valid = 1'b0; else in_valid4 = 1'b0;
      chk("beat_accept", {511'd0, ok}, 512'd1);
   endtask

   task automatic push(input logic [1:0] wid, input logic [1:0] step, input logic [7:0] tag,
                       input logic [511:0] a, input logic [511:0] b, input logic [511:0] c);
      exp_t e;
      e.wid = wid; e.step = step; e.tag = tag; e.a = a; e.b = b; e.c = c;
      sb.push_back(e);
   endtask

   // Scoreboard: every tile handed over on the default build must be the oldest expected one.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_tile", 512'd1, 512'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_wid", {510'd0, out_wid}, {510'd0, mon_e.wid});
            chk("sb_step", {510'd0, out_step}, {510'd0, mon_e.step});
            chk("sb_tag", {504'd0, out_tag}, {504'd0, mon_e.tag});
            chk("sb_a", out_a, mon_e.a);
            chk("sb_b", out_b, mon_e.b);
            chk("sb_c", out_c, mon_e.c);
         end
      end
   end

   initial begin
      int cyc;
      logic [511:0] a_exp_hold, a_exp_next;
      logic [255:0] fa, fb, fc;
      logic [255:0] a4e, b4e, c4e;

      rst = 1'b1;
      flush = 0; out_ready = 0; flush4 = 0; out_ready4 = 0;
      drive(0, 1'b0, 2'd0, 2'd0, 8'd0, '0, '0, '0);
      drive(1, 1'b0, 2'd0, 2'd0, 8'd0, '0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {511'd0, out_valid}, 512'd0);
      chk("rst_busy", {511'd0, busy}, 512'd0);
      chk("rst_stalls", {496'd0, foreign_stalls}, 512'd0);
      chk("rst_out_a", out_a, 512'd0);
      chk("rst_out_wid", {510'd0, out_wid}, 512'd0);
      chk("rst_out_tag", {504'd0, out_tag}, 512'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic tile, then a back-to-back tile with out_ready held high
      out_ready = 1;
      push(2'd1, 2'd0, 8'h5A, {fill8(8'h22), fill8(8'h11)}, {fill8(8'h44), fill8(8'h33)},
           {fill8(8'h66), fill8(8'h55)});
      send(0, 2'd1, 2'd0, 8'h5A, fill8(8'h11), fill8(8'h33), fill8(8'h55), cyc);
      chk("t1_busy", {511'd0, busy}, 512'd1);
      chk("t1_not_early", {511'd0, out_valid}, 512'd0);
      send(0, 2'd1, 2'd0, 8'h5A, fill8(8'h22), fill8(8'h44), fill8(8'h66), cyc);
      chk("t1_latency", {511'd0, out_valid}, 512'd1);
      chk("t1_idle", {511'd0, busy}, 512'd0);
      push(2'd3, 2'd2, 8'h77, {fill8(8'h88), fill8(8'h77)}, {fill8(8'hAA), fill8(8'h99)},
           {fill8(8'hCC), fill8(8'hBB)});
      send(0, 2'd3, 2'd2, 8'h77, fill8(8'h77), fill8(8'h99), fill8(8'hBB), cyc);
      chk("t2_nobubble0", cyc, 512'd1);
      send(0, 2'd3, 2'd2, 8'h77, fill8(8'h88), fill8(8'hAA), fill8(8'hCC), cyc);
      chk("t2_nobubble1", cyc, 512'd1);
      @(posedge clk); #1;
      chk("t2_drained", {511'd0, out_valid}, 512'd0);

      // Foreign warp refused while warp 1 holds the lock
      push(2'd1, 2'd0, 8'h10, {fill8(8'h02), fill8(8'h01)}, {fill8(8'h04), fill8(8'h03)},
           {fill8(8'h06), fill8(8'h05)});
      send(0, 2'd1, 2'd0, 8'h10, fill8(8'h01), fill8(8'h03), fill8(8'h05), cyc);
      drive(0, 1'b1, 2'd2, 2'd0, 8'h20, fill8(8'hEE), fill8(8'hEE), fill8(8'hEE));
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("foreign_ready", {511'd0, in_ready}, 512'd0);
         @(posedge clk); #1;
      end
      in_valid = 0;
      chk("foreign_count", {496'd0, foreign_stalls}, 512'd3);
      send(0, 2'd1, 2'd0, 8'h10, fill8(8'h02), fill8(8'h04), fill8(8'h06), cyc);
      @(posedge clk); #1;

      // Held tile A, tile B collects behind it; drain and reload in the same cycle
      out_ready = 0;
      a_exp_hold = {fill8(8'hA2), fill8(8'hA1)};
      a_exp_next = {fill8(8'hB2), fill8(8'hB1)};
      push(2'd0, 2'd1, 8'hA0, a_exp_hold, {fill8(8'hA4), fill8(8'hA3)}, {fill8(8'hA6), fill8(8'hA5)});
      send(0, 2'd0, 2'd1, 8'hA0, fill8(8'hA1), fill8(8'hA3), fill8(8'hA5), cyc);
      send(0, 2'd0, 2'd1, 8'hA0, fill8(8'hA2), fill8(8'hA4), fill8(8'hA6), cyc);
      chk("hold_valid", {511'd0, out_valid}, 512'd1);
      push(2'd2, 2'd3, 8'hB0, a_exp_next, {fill8(8'hB4), fill8(8'hB3)}, {fill8(8'hB6), fill8(8'hB5)});
      send(0, 2'd2, 2'd3, 8'hB0, fill8(8'hB1), fill8(8'hB3), fill8(8'hB5), cyc);
      chk("hold_beat0_free", cyc, 512'd1);
      drive(0, 1'b1, 2'd2, 2'd3, 8'hB0, fill8(8'hB2), fill8(8'hB4), fill8(8'hB6));
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("hold_last_stalled", {511'd0, in_ready}, 512'd0);
         chk("hold_stable", out_a, a_exp_hold);
         @(posedge clk); #1;
      end
      out_ready = 1;
      #1;
      chk("drain_ready", {511'd0, in_ready}, 512'd1);
      @(posedge clk); #1;
      in_valid = 0;
      chk("reload_valid", {511'd0, out_valid}, 512'd1);
      chk("reload_data", out_a, a_exp_next);
      chk("match_stall_not_foreign", {496'd0, foreign_stalls}, 512'd3);
      @(posedge clk); #1;
      chk("reload_drained", {511'd0, out_valid}, 512'd0);

      // Flush: refuses beats, abandons the partial tile, leaves the held tile alone
      out_ready = 0;
      a_exp_hold = {fill8(8'hC2), fill8(8'hC1)};
      push(2'd2, 2'd2, 8'hC0, a_exp_hold, {fill8(8'hC4), fill8(8'hC3)}, {fill8(8'hC6), fill8(8'hC5)});
      send(0, 2'd2, 2'd2, 8'hC0, fill8(8'hC1), fill8(8'hC3), fill8(8'hC5), cyc);
      send(0, 2'd2, 2'd2, 8'hC0, fill8(8'hC2), fill8(8'hC4), fill8(8'hC6), cyc);
      flush = 1;
      drive(0, 1'b1, 2'd3, 2'd0, 8'hD0, fill8(8'hD1), fill8(8'hD1), fill8(8'hD1));
      #1;
      chk("flush_ready", {511'd0, in_ready}, 512'd0);
      @(posedge clk); #1;
      chk("flush_no_accept", {511'd0, busy}, 512'd0);
      flush = 0;
      send(0, 2'd3, 2'd0, 8'hD0, fill8(8'hD1), fill8(8'hD1), fill8(8'hD1), cyc);
      chk("flush_pre_busy", {511'd0, busy}, 512'd1);
      flush = 1;
      @(posedge clk); #1;
      flush = 0;
      chk("flush_busy", {511'd0, busy}, 512'd0);
      chk("flush_hold_valid", {511'd0, out_valid}, 512'd1);
      chk("flush_hold_data", out_a, a_exp_hold);
      push(2'd0, 2'd1, 8'hE0, {fill8(8'hE2), fill8(8'hE1)}, {fill8(8'hE4), fill8(8'hE3)},
           {fill8(8'hE6), fill8(8'hE5)});
      send(0, 2'd0, 2'd1, 8'hE0, fill8(8'hE1), fill8(8'hE3), fill8(8'hE5), cyc);
      out_ready = 1;
      send(0, 2'd0, 2'd1, 8'hE0, fill8(8'hE2), fill8(8'hE4), fill8(8'hE6), cyc);
      repeat (2) @(posedge clk);
      #1;

      // Wide build: four beats make one tile, counter wraps for the next tile
      for (int k = 0; k < 4; k++) begin
         fa = fill8(8'h10 + 8'(k)); fb = fill8(8'h20 + 8'(k)); fc = fill8(8'h30 + 8'(k));
         a4e[k*64 +: 64] = fa[63:0]; b4e[k*64 +: 64] = fb[63:0]; c4e[k*64 +: 64] = fc[63:0];
         send(1, 2'd2, 2'd3, 8'hA5, fa, fb, fc, cyc);
         if (k < 3) chk("w4_busy", {511'd0, busy4}, 512'd1);
      end
      chk("w4_valid", {511'd0, out_valid4}, 512'd1);
      chk("w4_idle", {511'd0, busy4}, 512'd0);
      chk("w4_a", {256'd0, out_a4}, {256'd0, a4e});
      chk("w4_b", {256'd0, out_b4}, {256'd0, b4e});
      chk("w4_c", {256'd0, out_c4}, {256'd0, c4e});
      chk("w4_wid", {510'd0, out_wid4}, 512'd2);
      chk("w4_step", {510'd0, out_step4}, 512'd3);
      chk("w4_tag", {504'd0, out_tag4}, 512'hA5);
      out_ready4 = 1;
      for (int k = 0; k < 4; k++) begin
         fa = fill8(8'h50 + 8'(k)); fb = fill8(8'h60 + 8'(k)); fc = fill8(8'h70 + 8'(k));
         a4e[k*64 +: 64] = fa[63:0]; b4e[k*64 +: 64] = fb[63:0]; c4e[k*64 +: 64] = fc[63:0];
         send(1, 2'd1, 2'd0, 8'h5A, fa, fb, fc, cyc);
      end
      chk("w4_wrap_valid", {511'd0, out_valid4}, 512'd1);
      chk("w4_wrap_a", {256'd0, out_a4}, {256'd0, a4e});
      chk("w4_wrap_c", {256'd0, out_c4}, {256'd0, c4e});
      chk("w4_wrap_wid", {510'd0, out_wid4}, 512'd1);

      // Stall counter saturation
      send(1, 2'd1, 2'd1, 8'h33, fill8(8'h01), fill8(8'h01), fill8(8'h01), cyc);
      drive(1, 1'b1, 2'd0, 2'd1, 8'h44, fill8(8'h02), fill8(8'h02), fill8(8'h02));
      repeat (70000) @(posedge clk);
      #1;
      in_valid4 = 0;
      chk("w4_stall_sat", {496'd0, foreign_stalls4}, 512'hFFFF);
      chk("w4_stall_ref_busy", {511'd0, busy4}, 512'd1);

      // Asynchronous reset mid-collection with a held tile
      out_ready = 0;
      send(0, 2'd1, 2'd2, 8'hF0, fill8(8'hF1), fill8(8'hF1), fill8(8'hF1), cyc);
      send(0, 2'd1, 2'd2, 8'hF0, fill8(8'hF2), fill8(8'hF2), fill8(8'hF2), cyc);
      send(0, 2'd2, 2'd0, 8'hF8, fill8(8'hF3), fill8(8'hF3), fill8(8'hF3), cyc);
      chk("pre_rst_valid", {511'd0, out_valid}, 512'd1);
      chk("pre_rst_busy", {511'd0, busy}, 512'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", {511'd0, out_valid}, 512'd0);
      chk("arst_busy", {511'd0, busy}, 512'd0);
      chk("arst_stalls", {496'd0, foreign_stalls}, 512'd0);
      chk("arst_out_a", out_a, 512'd0);
      chk("arst_out_tag", {504'd0, out_tag}, 512'd0);
      chk("arst_w4_stalls", {496'd0, foreign_stalls4}, 512'd0);
      chk("sb_empty", sb.size(), 512'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
